bitrev_flow_ctrl: RTL
=====================

BITREV_FLOW_CTRL -- requirements
Module: bitrev_flow_ctrl

Interface
REQ-001 SHALL have parameter LGSIZE, default 5, meaning log2 FFT size; the frame is P = 2^(LGSIZE-1) sample pairs.
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  upstream sample pair available.
REQ-005 SHALL have port o_ready  output  1  controller accepts the upstream pair this cycle.
REQ-006 SHALL have port i_sync  input  1  upstream marks pair 0 of a frame.
REQ-007 SHALL have port i_flush  input  1  end-of-stream request: drain the last frame.
REQ-008 SHALL have port o_ce  output  1  clock enable to the bit-reverse datapath.
REQ-009 SHALL have port o_dp_reset  output  1  synchronous reset to the datapath.
REQ-010 SHALL have port o_zero  output  1  datapath input mux selects zero (flush padding).
REQ-011 SHALL have port o_valid  output  1  datapath output pair valid downstream.
REQ-012 SHALL have port i_ready  input  1  downstream accepts the output pair.
REQ-013 SHALL have port o_first  output  1  o_valid pair is pair 0 of its frame.
REQ-014 SHALL have port o_last  output  1  o_valid pair is pair P-1 of its frame.
REQ-015 SHALL have port o_err  output  1  sticky sync-error flag (see Configuration).

Function
REQ-016 SHALL implement FSM states FILL, RUN, FLUSH with an LGSIZE-1 bit pair counter wcnt that increments, wrapping to 0, on every o_ce.
REQ-017 SHALL drive o_ready = 1 in FILL; in RUN o_ready = i_ready or not o_valid; in FLUSH o_ready = 0.
REQ-018 SHALL drive o_ce combinationally: FILL/RUN = i_valid and o_ready; FLUSH = i_ready or not o_valid; o_zero = 1 only in FLUSH.
REQ-019 FILL SHALL move to RUN on the o_ce where wcnt = P-1; no output is valid during FILL.
REQ-020 Every o_ce in RUN or FLUSH SHALL set o_valid next cycle, with o_first = (wcnt = 0) and o_last = (wcnt = P-1) registered from that o_ce.
REQ-021 o_valid SHALL clear on i_ready when no o_ce occurs that cycle; o_valid, o_first, o_last SHALL hold while o_valid and not i_ready.
REQ-022 Output latency: the pair accepted at o_ce n appears in bit-reversed order, with the first output pair of a frame produced by the o_ce following the frame's last write (P+1 o_ce after frame start).
REQ-023 RUN SHALL enter FLUSH when i_flush = 1, wcnt = 0 and no o_ce occurs that cycle; i_flush elsewhere is held off until those conditions hold; i_flush in FILL is ignored.
REQ-024 FLUSH SHALL issue exactly P o_ce, then pulse o_dp_reset for one cycle and enter FILL with wcnt = 0.
REQ-025 Simultaneous i_flush and accepted pair at wcnt = 0 SHALL accept the pair and stay in RUN.

Reset
REQ-026 i_reset SHALL force FILL, wcnt = 0, o_valid = o_first = o_last = o_err = 0, and assert o_dp_reset the same cycle and the following cycle.
REQ-027 Reset mid-frame or mid-flush SHALL discard all in-flight data; no o_valid until a full new frame is filled.

Configuration
REQ-028 With BITREV_FLOW_CTRL_SYNC_CHECK_EN defined, an accepted pair with i_sync != (wcnt = 0) SHALL set o_err, pulse o_dp_reset, clear o_valid, and re-enter FILL, taking that pair as pair 0 if i_sync = 1 (wcnt = 1 next).
REQ-029 Without BITREV_FLOW_CTRL_SYNC_CHECK_EN, i_sync SHALL be ignored and o_err SHALL be constant 0.

Verification (LGSIZE = 5, P = 16)
REQ-030 Reset, then 16 continuous valid pairs with i_ready = 1 -> o_valid stays 0 throughout, state RUN after pair 16; pair 17 -> o_valid = 1, o_first = 1 next cycle.
REQ-031 Streaming in RUN with i_ready held 0 for 3 cycles -> o_ready = 0, o_ce = 0, o_valid/o_first/o_last unchanged for 3 cycles, resume without loss.
REQ-032 Two frames then i_flush = 1 at wcnt = 0 -> exactly 16 o_ce with o_zero = 1, o_last on 16th output, one-cycle o_dp_reset, FILL.
REQ-033 i_reset asserted at wcnt = 7 in RUN -> o_valid = 0 next cycle, o_dp_reset high 2 cycles, 16 new pairs produce no output.
REQ-034 SYNC_CHECK_EN defined, i_sync = 1 at wcnt = 5 -> o_err = 1 sticky, o_dp_reset pulse, FILL with wcnt = 1; undefined -> no effect, o_err = 0.
REQ-035 i_flush and accepted pair together at wcnt = 0 -> pair accepted, wcnt = 1, state stays RUN.

Source files
------------

// File: rtl/bitrev_flow_ctrl.sv
// Flow-control FSM for a streaming bit-reverse stage: fill a frame, stream, and drain with zero padding.
// Optional sync checking is enabled by defining BITREV_FLOW_CTRL_SYNC_CHECK_EN.
module bitrev_flow_ctrl #(
    parameter int LGSIZE = 5
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_valid,
    output logic o_ready,
    input  logic i_sync,
    input  logic i_flush,
    output logic o_ce,
    output logic o_dp_reset,
    output logic o_zero,
    output logic o_valid,
    input  logic i_ready,
    output logic o_first,
    output logic o_last,
    output logic o_err
);
    localparam int CW = LGSIZE - 1;
    localparam logic [CW-1:0] LAST_PAIR = '1;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] wcnt;
    logic          dp_reset_q;
    logic          sync_err;
    logic          wcnt_zero;
    logic          wcnt_last;

    assign wcnt_zero = (wcnt == '0);
    assign wcnt_last = (wcnt == LAST_PAIR);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        o_ready = 1'b0;
        o_ce    = 1'b0;
        case (state)
            FILL: begin
                o_ready = 1'b1;
                o_ce    = i_valid;
            end
            RUN: begin
                o_ready = i_ready || !o_valid;
                o_ce    = i_valid && (i_ready || !o_valid);
            end
            FLUSH: begin
                o_ce = i_ready || !o_valid;
            end
            default: ;
        endcase
    end

    assign o_zero = (state == FLUSH);

    // The datapath reset is asserted in the reset cycle itself and in the cycle after it.
    assign o_dp_reset = i_reset || dp_reset_q;

`ifdef BITREV_FLOW_CTRL_SYNC_CHECK_EN
    assign sync_err = o_ce && (state != FLUSH) && (i_sync != wcnt_zero);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err <= 1'b0;
        end else if (sync_err) begin
            o_err <= 1'b1;
        end
    end
`else
    assign sync_err = 1'b0;
    assign o_err    = 1'b0;
`endif

    // NOTE: later non-blocking assignments in this block override earlier ones, so the
    // sync-error recovery at the bottom takes priority over the normal state update.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= FILL;
            wcnt       <= '0;
            o_valid    <= 1'b0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            dp_reset_q <= 1'b1;
        end else begin
            dp_reset_q <= 1'b0;

            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            if (o_ce) begin
                wcnt <= wcnt + 1'b1;
            end

            // Outputs only exist once a whole frame is resident in the datapath.
            if (o_ce && (state != FILL)) begin
                o_valid <= 1'b1;
                o_first <= wcnt_zero;
                o_last  <= wcnt_last;
            end

            case (state)
                FILL: begin
                    if (o_ce && wcnt_last) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (i_flush && wcnt_zero && !o_ce) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (o_ce && wcnt_last) begin
                        state      <= FILL;
                        dp_reset_q <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase

            if (sync_err) begin
                state      <= FILL;
                wcnt       <= CW'(i_sync);
                o_valid    <= 1'b0;
                dp_reset_q <= 1'b1;
            end
        end
    end
endmodule
